// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA channel arbiter: channel index type and FSM state encoding.
package dma_arb_pkg;

  localparam int NUM_CH_DEF = 4;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_rot_prio_enc.sv
// Combinational priority encoder; the search starts at `start` when rot_en is set and at 0 otherwise,
// wrapping modulo NUM_CH.
module dma_rot_prio_enc #(
  parameter  int NUM_CH = 4,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [IW-1:0]     start,
  input  logic              rot_en,
  output logic              any,
  output logic [IW-1:0]     winner
);

  logic [IW:0] base;
  logic [IW:0] idx;

  // Walk from the farthest offset down to the nearest so the closest pending channel is written last.
  always_comb begin
    base   = rot_en ? {1'b0, start} : '0;
    idx    = '0;
    any    = |pend;
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_CH)) idx = idx - (IW+1)'(NUM_CH);
      if (pend[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel request arbiter and HRQ/HLDA hold sequencer for the 4-channel DMA controller.
// Optional: define DMA_ARB_SWREQ_EN to merge the software request register into the pending vector.
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int IW     = $clog2(NUM_CH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Dreq,
  input  logic              DreqSense,
  input  logic              DackSense,
  input  logic              RotatePri,
  input  logic              CtrlDisable,
  input  logic [NUM_CH-1:0] Mask,
  input  logic [NUM_CH-1:0] SwReq,
  input  logic              Hlda,
  input  logic              XferDone,
  output logic              Hrq,
  output logic [NUM_CH-1:0] Dack,
  output logic              GrantValid,
  output logic [IW-1:0]     GrantCh
);

  // state   | meaning
  // IDLE    | no hold requested, waiting for an eligible request
  // REQ     | HRQ asserted, waiting for HLDA
  // GRANT   | channel granted, DACK active until XferDone or HLDA loss
  // RELEASE | one cycle of HRQ low after a completed service

  arb_state_t        state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              gv_q, gv_d;
  logic [IW-1:0]     ch_q, ch_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] dack_q, dack_d;

  logic [NUM_CH-1:0] pend;
  logic              any;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     ptr_next;
  logic [NUM_CH-1:0] grant_oh;

`ifdef DMA_ARB_SWREQ_EN
  assign pend = ((Dreq ^ {NUM_CH{DreqSense}}) & ~Mask) | SwReq;
`else
  logic unused_swreq;
  assign unused_swreq = ^SwReq;
  assign pend = (Dreq ^ {NUM_CH{DreqSense}}) & ~Mask;
`endif

  dma_rot_prio_enc #(.NUM_CH(NUM_CH)) u_enc (
    .pend   (pend),
    .start  (ptr_q),
    .rot_en (RotatePri),
    .any    (any),
    .winner (winner)
  );

  assign ptr_next = (ch_q == IW'(NUM_CH - 1)) ? '0 : ch_q + IW'(1);

  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    gv_d    = gv_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;

    // Pointer advance is independent of CtrlDisable so a finished service still rotates.
    if (state_q == GRANT && XferDone && RotatePri) ptr_d = ptr_next;

    if (CtrlDisable) begin
      state_d = IDLE;
      hrq_d   = 1'b0;
      gv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            state_d = REQ;
            hrq_d   = 1'b1;
          end
        end
        REQ: begin
          if (!any) begin
            state_d = IDLE;
            hrq_d   = 1'b0;
          end else if (Hlda) begin
            state_d = GRANT;
            gv_d    = 1'b1;
            ch_d    = winner;
          end
        end
        GRANT: begin
          if (XferDone) begin
            state_d = RELEASE;
            hrq_d   = 1'b0;
            gv_d    = 1'b0;
          end else if (!Hlda) begin
            state_d = IDLE;
            hrq_d   = 1'b0;
            gv_d    = 1'b0;
          end
        end
        RELEASE: begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end
        default: begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
        end
      endcase
    end

    grant_oh = gv_d ? (NUM_CH'(1) << ch_d) : '0;
    dack_d   = grant_oh ^ {NUM_CH{~DackSense}};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      gv_q    <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      dack_q  <= {NUM_CH{~DackSense}};
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      gv_q    <= gv_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      dack_q  <= dack_d;
    end
  end

  assign Hrq        = hrq_q;
  assign GrantValid = gv_q;
  assign GrantCh    = ch_q;
  assign Dack       = dack_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel request arbiter and bus-hold sequencer for the 4-channel 8237A-style DMA controller.
- Normalises DREQ polarity and merges in software requests. Applies the mask and the controller-disable bit, and picks one channel by fixed or rotating priority.
- Runs the HRQ/HLDA hold handshake and drives DACK with the programmed polarity.
- Sits between the command/mask/request registers and the transfer timing FSM. The timing FSM reports end-of-service via XferDone.

Parameters:
- NUM_CH, 4, number of DMA channels (the design uses 4; width logic must scale).

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Dreq  input  NUM_CH  raw DMA request pins.
- DreqSense  input  1  Command[6]: 0 = DREQ active high, 1 = DREQ active low.
- DackSense  input  1  Command[7]: 0 = DACK active low, 1 = DACK active high.
- RotatePri  input  1  Command[4]: 0 = fixed priority, 1 = rotating priority.
- CtrlDisable  input  1  Command[2]: controller disable.
- Mask  input  NUM_CH  mask register; 1 = channel masked.
- SwReq  input  NUM_CH  request register (software requests; ignore Mask).
- Hlda  input  1  hold acknowledge from CPU.
- XferDone  input  1  one-cycle pulse from the timing FSM: service of the granted channel finished (TC or EOP).
- Hrq  output  1  hold request to CPU.
- Dack  output  NUM_CH  DMA acknowledge, polarity per DackSense.
- GrantValid  output  1  a channel is currently granted.
- GrantCh  output  $clog2(NUM_CH)  index of the granted channel.

Behaviour:
- Pending vector: pend = ((Dreq ^ {NUM_CH{DreqSense}}) & ~Mask) | SwReq. Eligible only when CtrlDisable = 0.
- States: IDLE, REQ, GRANT, RELEASE. All outputs are registered.
- Reset values: state IDLE, Hrq 0, GrantValid 0, GrantCh 0, rotation pointer 0.
- Dack inactive level is {NUM_CH{~DackSense}}. At reset this is all ones when DackSense = 0.
- Dack is always computed from the registered grant XOR-ed with the live DackSense.
- IDLE:
  - If pend != 0 and CtrlDisable = 0: Hrq = 1 on the next edge, go to REQ.
- REQ:
  - Hrq held at 1.
  - If pend becomes 0: drop Hrq next cycle, go to IDLE.
  - If Hlda = 1 and pend != 0: latch the winner of the current pend into GrantCh, set GrantValid. Dack[GrantCh] goes active on the next edge. Go to GRANT.
  - Hlda to Dack latency is exactly 1 cycle.
- Priority:
  - Fixed mode: ch0 is highest, ch(NUM_CH-1) is lowest.
  - Rotating mode: the search starts at the pointer and wraps modulo NUM_CH.
  - On XferDone in rotating mode, pointer = GrantCh+1 (mod NUM_CH), so the serviced channel becomes lowest.
  - In fixed mode the pointer is not updated.
- GRANT:
  - Hrq, GrantValid and Dack are held. Requests from other channels do not preempt.
  - If XferDone = 1: deassert Dack, GrantValid and Hrq next cycle, go to RELEASE.
  - If Hlda drops to 0 without XferDone (CPU reclaim): same deassertion next cycle, go to IDLE, pointer unchanged.
- RELEASE:
  - Exactly one cycle with Hrq 0, which guarantees a minimum HRQ low pulse. Then go to IDLE.
- CtrlDisable = 1 in any state:
  - Next cycle: Hrq 0, GrantValid 0, Dack inactive, state IDLE.
  - No new request while it is held.
- Simultaneous events:
  - XferDone and Hlda drop in the same cycle: XferDone wins, go to RELEASE with pointer update.
  - CtrlDisable together with XferDone: CtrlDisable wins; pointer is still updated.
- A change of DackSense while granted flips the Dack polarity on the next edge only. The grant is unaffected.

Optional Feature:
- DMA_ARB_SWREQ_EN:
  - Defined: SwReq participates in pend as above.
  - Undefined: the SwReq port exists but is ignored, so pend excludes it. The request register is handled entirely in hardware-request form.

Decomposition:
- Package dma_arb_pkg holds:
  - NUM_CH_DEF = 4
  - typedef ch_idx_t (logic [$clog2(NUM_CH_DEF)-1:0])
  - enum arb_state_t {IDLE, REQ, GRANT, RELEASE}
- Sub-module dma_rot_prio_enc:
  - Combinational rotating priority encoder.
  - Inputs: pend, start pointer, rotate enable.
  - Outputs: any, winner index.
  - Reused by the cascade logic later.

Test Plan:
- DreqSense=0, Dreq=4'b0100, Mask=0, Hlda raised 2 cycles after Hrq -> Hrq at cycle 1, Dack=4'b1011 (DackSense=0) one cycle after Hlda, GrantCh=2. XferDone -> Dack=4'b1111, Hrq low ≥1 cycle.
- Fixed priority, Dreq=4'b1010 -> grant ch1. After XferDone with Dreq still 4'b1010 -> grant ch1 again.
- RotatePri=1, Dreq=4'b1111 held, 4 services -> grant order 0,1,2,3,0.
- Mask=4'b0001, Dreq=4'b0001 -> Hrq stays 0. Same with SwReq=4'b0001 (SWREQ_EN defined) -> grant ch0. Same with SWREQ_EN undefined -> no Hrq.
- CtrlDisable=1 mid-GRANT -> next cycle Hrq=0 and Dack inactive. Further Dreq=4'b1111 -> no Hrq while disabled.
- Hlda dropped mid-GRANT, no XferDone, RotatePri=1 -> Dack inactive next cycle, state IDLE, pointer unchanged (the same channel wins on re-request).
